// File: rtl/led_trail_pwm_pkg.sv
// Shared constants and helpers for the LED trail PWM block.
// Holds lane count, parameter defaults, level ceiling and counter sizing.
package led_trail_pkg;

    localparam int LANES           = 8;
    localparam int PWM_BITS_DEF    = 4;
    localparam int DECAY_TICKS_DEF = 16;
    localparam int DECAY_STEP_DEF  = 1;

    // Full-brightness level for a given PWM width.
    function automatic int level_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Decay timer width; a single-tick timer still needs one bit.
    function automatic int cnt_width(input int ticks);
        return (ticks <= 1) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/led_trail_pwm_if.sv
// Pattern-in / LED-out bundle between the pattern source and the PWM block.
// Ports: enable, pattern_in (8), led_out (8), level_out (8*PWM_BITS), frame_start.
interface led_trail_pwm_if #(
    parameter int PWM_BITS = 4
);

    logic                                     enable;
    logic [led_trail_pkg::LANES-1:0]          pattern_in;
    logic [led_trail_pkg::LANES-1:0]          led_out;
    logic [led_trail_pkg::LANES*PWM_BITS-1:0] level_out;
    logic                                     frame_start;

    modport master (
        output enable,
        output pattern_in,
        input  led_out,
        input  level_out,
        input  frame_start
    );

    modport slave (
        input  enable,
        input  pattern_in,
        output led_out,
        output level_out,
        output frame_start
    );

endinterface

// File: rtl/led_trail_pwm_lane.sv
// One LED lane: brightness register with saturating decay and PWM compare.
// Ports: clk, rst, enable, lit, decay_tick, pwm_cnt in; level, led out.
module led_trail_lane
    import led_trail_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                lit,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(level_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] level_next;

    // Lit beats decay; compare before subtracting so the level never wraps.
    always_comb begin
        level_next = level;
        if (lit) begin
            level_next = MAX;
        end else if (decay_tick) begin
            level_next = (level < STEP) ? '0 : level - STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            led   <= 1'b0;
        end else if (enable) begin
            level <= level_next;
            // MAX is forced on so the top level gets 100% duty, not 15/16.
            led   <= (level == MAX) || (pwm_cnt < level);
        end else begin
            led   <= 1'b0;
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// Turns the knight-rider pattern into fading per-LED PWM drive.
// Ports: clk, rst (sync, active-high); bus (slave) carries enable/pattern/LED/debug.
module led_trail_pwm
    import led_trail_pkg::*;
#(
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int DECAY_TICKS = DECAY_TICKS_DEF,
    parameter int DECAY_STEP  = DECAY_STEP_DEF
) (
    input  logic           clk,
    input  logic           rst,
    led_trail_pwm_if.slave bus
);

    localparam int             DW    = cnt_width(DECAY_TICKS);
    localparam logic [DW-1:0]  DLAST = DW'(DECAY_TICKS - 1);

    logic [LANES-1:0]    pat_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_next;
    logic [DW-1:0]       decay_cnt;
    logic                decay_tick;
    logic                frame_start;
    logic [LANES-1:0]    led;
    logic [PWM_BITS-1:0] level [LANES];

    assign pwm_next   = pwm_cnt + 1'b1;
    assign decay_tick = bus.enable && (decay_cnt == DLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q       <= '0;
            pwm_cnt     <= '0;
            decay_cnt   <= '0;
            frame_start <= 1'b0;
        end else if (bus.enable) begin
            pat_q       <= bus.pattern_in;
            pwm_cnt     <= pwm_next;
            decay_cnt   <= (decay_cnt == DLAST) ? '0 : decay_cnt + 1'b1;
            frame_start <= (pwm_next == '0);
        end else begin
            frame_start <= 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        led_trail_lane #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .enable     (bus.enable),
            .lit        (pat_q[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt),
            .level      (level[i]),
            .led        (led[i])
        );
        assign bus.level_out[i*PWM_BITS +: PWM_BITS] = level[i];
    end

    assign bus.led_out     = led;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Randomised and directed bench for led_trail_pwm against a cycle model.
// Drives two instances: the main one and a slow-decay one for duty cycle.
module tb_led_trail_pwm;

    localparam int DT   = 4;
    localparam int STEP = 4;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    led_trail_pwm_if #(.PWM_BITS(4)) bus1 ();
    led_trail_pwm_if #(.PWM_BITS(4)) bus2 ();

    led_trail_pwm #(
        .PWM_BITS    (4),
        .DECAY_TICKS (DT),
        .DECAY_STEP  (STEP)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    led_trail_pwm #(
        .PWM_BITS    (4),
        .DECAY_TICKS (1000),
        .DECAY_STEP  (8)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Reference: behaviour as a function of enabled-cycle count since reset.
    int         m_lvl [8];
    logic [7:0] m_pat;
    logic [7:0] m_led;
    logic       m_fs;
    int         m_en;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_levels();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'(m_lvl[i]);
        return v;
    endfunction

    task automatic model_edge();
        int  pwm;
        bit  tick;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_lvl[i] = 0;
            m_pat = '0;
            m_led = '0;
            m_fs  = 1'b0;
            m_en  = 0;
        end else if (bus1.enable) begin
            pwm  = m_en % 16;
            tick = (m_en % DT) == DT - 1;
            for (int i = 0; i < 8; i++)
                m_led[i] = (m_lvl[i] == 15) || (pwm < m_lvl[i]);
            for (int i = 0; i < 8; i++) begin
                if (m_pat[i])  m_lvl[i] = 15;
                else if (tick) m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
            end
            m_fs  = ((m_en + 1) % 16) == 0;
            m_pat = bus1.pattern_in;
            m_en++;
        end else begin
            m_led = '0;
            m_fs  = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("led_out", 64'(bus1.led_out), 64'(m_led));
        check("level_out", 64'(bus1.level_out), 64'(exp_levels()));
        check("frame_start", 64'(bus1.frame_start), 64'(m_fs));
    endtask

    function automatic int lvl7();
        return int'(bus1.level_out[31:28]);
    endfunction

    initial begin
        int first;
        int found;
        int cnt;
        int seq [$];
        int prev;
        logic e;

        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
        m_pat = '0;
        m_led = '0;
        m_fs  = 1'b0;
        m_en  = 0;

        bus2.enable     = 1'b0;
        bus2.pattern_in = '0;

        // Reset with everything lit at the input.
        rst             = 1'b1;
        bus1.enable     = 1'b1;
        bus1.pattern_in = 8'hFF;
        step();
        step();
        check("rst_led", 64'(bus1.led_out), 64'h0);
        check("rst_lvl", 64'(bus1.level_out), 64'h0);

        // First frame_start after 16 enabled cycles.
        rst             = 1'b0;
        bus1.pattern_in = 8'h00;
        first           = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus1.frame_start) begin
                first = c;
                break;
            end
        end
        check("first_fs", 64'(first), 64'd16);

        // Full lit lane 7.
        bus1.pattern_in = 8'h80;
        step();
        step();
        check("lit_lvl7", 64'(lvl7()), 64'd15);
        for (int c = 0; c < 6; c++) begin
            step();
            check("lit_led", 64'(bus1.led_out), 64'h80);
        end

        // Decay to zero with saturation.
        bus1.pattern_in = 8'h00;
        prev = 15;
        for (int c = 0; c < 24; c++) begin
            step();
            if (lvl7() != prev) seq.push_back(lvl7());
            prev = lvl7();
        end
        check("decay_n", 64'(seq.size()), 64'd4);
        if (seq.size() == 4) begin
            check("decay_0", 64'(seq[0]), 64'd11);
            check("decay_1", 64'(seq[1]), 64'd7);
            check("decay_2", 64'(seq[2]), 64'd3);
            check("decay_3", 64'(seq[3]), 64'd0);
        end

        // Lit bit lands on the decay_tick edge.
        for (int c = 0; c < 4 && (m_en % DT) != DT - 2; c++) step();
        bus1.pattern_in = 8'h01;
        step();
        bus1.pattern_in = 8'h00;
        step();
        check("prio_lvl0", 64'(bus1.level_out[3:0]), 64'd15);

        // Fade lane 7 to 7, then freeze.
        bus1.pattern_in = 8'h80;
        step();
        step();
        step();
        bus1.pattern_in = 8'h00;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (lvl7() == 7) begin
                found = 1;
                break;
            end
        end
        check("reach7", 64'(found), 64'd1);
        bus1.enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("hold_lvl7", 64'(lvl7()), 64'd7);
            check("hold_led", 64'(bus1.led_out), 64'h0);
        end
        bus1.enable = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (lvl7() == 3) begin
                found = 1;
                break;
            end
        end
        check("reach3", 64'(found), 64'd1);
        rst = 1'b1;
        step();
        check("midrst_lvl", 64'(bus1.level_out), 64'h0);
        check("midrst_led", 64'(bus1.led_out), 64'h0);
        rst = 1'b0;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            bus1.enable = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       bus1.pattern_in = 8'($urandom);
                1:       bus1.pattern_in = 8'(1 << $urandom_range(0, 7));
                default: bus1.pattern_in = 8'h00;
            endcase
            step();
        end
        rst = 1'b0;

        // Duty cycle at level 7 on the slow-decay instance.
        bus2.enable     = 1'b1;
        bus2.pattern_in = 8'h80;
        repeat (4) @(posedge clk);
        #1;
        bus2.pattern_in = 8'h00;
        found = 0;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk);
            #1;
            if (bus2.level_out[31:28] == 4'd7) begin
                found = 1;
                break;
            end
        end
        check("duty_reach7", 64'(found), 64'd1);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus2.frame_start) begin
                found = 1;
                break;
            end
        end
        check("duty_fs", 64'(found), 64'd1);
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            // led in cycle j reflects the counter value of cycle j-1.
            e = (((j + 15) % 16) < 7);
            check("duty_pos", 64'(bus2.led_out[7]), 64'(e));
            if (bus2.led_out[7]) cnt++;
            @(posedge clk);
            #1;
        end
        check("duty_cnt", 64'(cnt), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream consumer of the 8-bit knight-rider LED pattern.
- Converts each pattern bit into a per-LED brightness level that jumps to full when the bit is lit, then decays step-wise after it goes dark, producing the classic fading "tail".
- Brightness is rendered on the physical LED pins by a shared PWM counter.
- Sits between the pattern generator output and the board LED pins.

Parameters:
- PWM_BITS, 4, width of brightness level and PWM counter; levels 0..2^PWM_BITS-1.
- DECAY_TICKS, 16, clock cycles between successive decay steps; must be >= 1.
- DECAY_STEP, 1, amount subtracted from a dark lane's level per decay step; must be 1..2^PWM_BITS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = run; 0 = freeze counters and levels, blank LEDs.
- pattern_in  in  8  pattern from the generator, sampled every cycle; bit i drives lane i.
- led_out  out  8  PWM-modulated LED drive, registered.
- level_out  out  8*PWM_BITS  current lane levels; lane i at [i*PWM_BITS +: PWM_BITS]; debug/observation.
- frame_start  out  1  one-cycle pulse, registered; high in the cycle where the PWM counter equals 0.

Behaviour:
- Reset: rst is sampled at posedge clk and has priority over everything, including enable.
  - Clears pat_q, all levels, pwm_cnt and decay_cnt.
  - led_out=0, level_out=0, frame_start=0 in the cycle after rst is sampled high.
  - Asserting reset mid-fade clears all state immediately; no partial decay survives.
- Input stage: pat_q <= pattern_in every enabled cycle. There is no valid strobe; the pattern is level-sampled.
- PWM counter, pwm_cnt:
  - Width PWM_BITS; increments by 1 every enabled cycle.
  - Wraps from 2^PWM_BITS-1 to 0.
  - frame_start <= (pwm_cnt_next == 0).
- Decay timer, decay_cnt:
  - Counts 0..DECAY_TICKS-1 and wraps to 0.
  - decay_tick is asserted combinationally when decay_cnt == DECAY_TICKS-1 and enable=1.
  - With DECAY_TICKS=1, decay_tick is asserted every enabled cycle.
- Per-lane level L[i], updated every enabled cycle, in priority order:
  1. pat_q[i]==1 -> L = MAX (2^PWM_BITS-1). A lit bit wins over a simultaneous decay_tick.
  2. Else if decay_tick -> L = L - DECAY_STEP, saturating at 0. Never wraps: when L < DECAY_STEP, the result is 0.
  3. Else hold.
- LED output, registered:
  - led_out[i] <= (L[i] == MAX) ? 1 : (pwm_cnt < L[i]).
  - L=MAX gives 100% duty, L=0 gives 0%, L=k gives duty k/2^PWM_BITS, high while pwm_cnt is 0..k-1.
- Latency:
  - A pattern_in edge sampled at clock k lands in pat_q after k.
  - Level updates after k+1.
  - level_out (a direct view of the L regs) reflects it after k+1; led_out after k+2.
- Enable low:
  - pwm_cnt, decay_cnt, pat_q and L all hold.
  - led_out is forced to 0 on the next clock; frame_start=0.
  - On re-enable, operation resumes from the held counts with no extra tick.
- Simultaneous events: a decay_tick in the same cycle as pwm_cnt wrap is independent; both take effect.
- All arithmetic is unsigned, PWM_BITS wide. The saturation compare is done before subtraction.

Decomposition:
- Package led_trail_pkg holds:
  - LANES=8;
  - the default PWM_BITS, DECAY_TICKS and DECAY_STEP constants;
  - the localparam function deriving LEVEL_MAX = 2^PWM_BITS-1;
  - the decay_cnt width calculation, clog2(DECAY_TICKS) with a minimum of 1.
- Sub-module led_trail_lane, instantiated 8 times:
  - inputs clk, rst, enable, lit, decay_tick, pwm_cnt;
  - outputs level, led.
  - It contains the level register, the saturating decay and the PWM compare.
- The top level owns pat_q, pwm_cnt, decay_cnt and frame_start.

Test Plan (bench params PWM_BITS=4, DECAY_TICKS=4, DECAY_STEP=4 unless noted):
- Reset: drive rst=1 for 2 cycles with pattern_in=0xFF -> led_out=0x00, level_out=0, frame_start=0. First frame_start occurs 16 enabled cycles after rst deasserts.
- Full lit: hold pattern_in=0x80 -> level lane7=15 two clocks after apply, led_out=0x80 at every cycle from the third clock onward, all other lanes 0.
- Decay with saturation: hold 0x80, then drop to 0x00 -> lane7 level steps 15->11->7->3->0, one step per decay_tick (every 4 cycles), then stays 0. It must not wrap to 15.
- PWM duty: with DECAY_TICKS=1000, freeze lane at level 7 -> over any 16-cycle frame led_out[7] is high exactly 7 cycles, aligned to pwm_cnt 0..6.
- Priority: present pattern bit high in the exact cycle of decay_tick -> level stays 15, not 11.
- Enable/reset mid-fade: lane at 7, drop enable for 10 cycles -> level_out holds 7, led_out=0x00, pwm_cnt frozen. Re-enable, then pulse rst while level is 3 -> level 0 and led_out 0 in the next cycle.
